// File: rtl/renode_inputs_scheduler.sv
// -----------------------------------------------------------------------------
// renode_inputs_scheduler
//
// Watches a bank of interrupt lines and turns every unreported level change
// into a single (address, level) message for a downstream sender. Changes are
// coalesced: the scheduler only remembers the last level it reported per line.
// A line is pending while its registered level differs from that value. An
// even number of toggles between reports therefore produces no message. An
// odd number produces one message carrying the final level. Pending lines are
// served round-robin, starting just after the line that was reported last.
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   inputs     interrupt line levels, synchronous to clk
//   mask       1 = line excluded from arbitration (its changes are still tracked)
//   enable     0 = no new grants (pending state still accumulates)
//   msg_valid  message offered to the sender (high for the whole SEND state)
//   msg_ready  sender accepts the offered message this cycle
//   msg_addr   index of the reported line, zero-extended to 32 bits
//   msg_data   level being reported for that line
//   pending    per-line "changed since last report" flags
//   busy       high while a message is being offered
// -----------------------------------------------------------------------------
module renode_inputs_scheduler #(
  parameter int InputsCount = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InputsCount-1:0] inputs,
  input  logic [InputsCount-1:0] mask,
  input  logic                   enable,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [31:0]            msg_addr,
  output logic                   msg_data,
  output logic [InputsCount-1:0] pending,
  output logic                   busy
);

  // Width of a line index; a single-line instance still needs one bit.
  localparam int PtrW = (InputsCount > 1) ? $clog2(InputsCount) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [InputsCount-1:0] level_q, level_d;
  logic [InputsCount-1:0] sent_q, sent_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]        addr_q, addr_d;
  logic                   data_q, data_d;

  logic [InputsCount-1:0] eligible;
  logic [PtrW-1:0]        grant_idx;
  logic                   grant_found;
  logic [PtrW-1:0]        next_ptr;

  // ---------------------------------------------------------------------------
  // Per-line change tracking
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < InputsCount; gi++) begin : g_line
    assign pending[gi]  = level_q[gi] ^ sent_q[gi];
    assign eligible[gi] = pending[gi] & ~mask[gi];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible line at or above rr_ptr, wrapping.
  // Candidates are walked from the farthest offset down to offset 0 so that the
  // nearest eligible line is the last one written and therefore wins.
  // The candidate is one bit wider than an index so rr_ptr + offset never
  // overflows before the wrap subtraction.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PtrW:0] cand;
    cand        = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int off = InputsCount - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_q} + (PtrW + 1)'(off);
      if (cand >= (PtrW + 1)'(InputsCount)) begin
        cand = cand - (PtrW + 1)'(InputsCount);
      end
      if (eligible[cand[PtrW-1:0]]) begin
        grant_idx   = cand[PtrW-1:0];
        grant_found = 1'b1;
      end
    end
  end

  // Pointer moves to the line after the one just reported, modulo InputsCount.
  assign next_ptr = (addr_q == PtrW'(InputsCount - 1)) ? '0 : addr_q + PtrW'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    level_d  = inputs;
    sent_d   = sent_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      IDLE: begin
        if (enable && grant_found) begin
          // Address and level are frozen here; later changes on the granted
          // line stay pending and are reported by a subsequent message.
          state_d = SEND;
          addr_d  = grant_idx;
          data_d  = level_q[grant_idx];
        end
      end
      SEND: begin
        // enable and mask are deliberately ignored: a message once offered is
        // never withdrawn.
        if (msg_ready) begin
          sent_d[addr_q] = data_q;
          rr_ptr_d       = next_ptr;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      sent_q   <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      sent_q   <= sent_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign msg_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign msg_addr  = 32'(addr_q);
  assign msg_data  = data_q;

endmodule
